// File: rtl/regbank_writer_pkg.sv
// regbank_writer_pkg: shared state encoding and size helpers for the register bank write side
package regbank_writer_pkg;
   localparam int DEF_N_BITS   = 32;
   localparam int DEF_SEL_BITS = 5;
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE     = 1'b0;
   localparam state_t ST_CLEARING = 1'b1;
   function automatic int n_regs(input int sel_bits);
      return 2 ** sel_bits;
   endfunction
   function automatic int n_lanes(input int n_bits);
      return n_bits / 8;
   endfunction
endpackage

// File: rtl/regbank_writer_decoder_n.sv
// decoder_n: enable-gated binary to one-hot decoder, write-side counterpart of the selector tree
module decoder_n
   import regbank_writer_pkg::*;
#(
   parameter int SEL_BITS = DEF_SEL_BITS
) (
   input  logic                        i_en,
   input  logic [SEL_BITS-1:0]         i_sel,
   output logic [n_regs(SEL_BITS)-1:0] o_onehot
);
   localparam int N = n_regs(SEL_BITS);
   assign o_onehot = i_en ? N'(1) << i_sel : '0;
endmodule

// File: rtl/regbank_writer.sv
// regbank_writer: byte-masked register bank writes with a sequenced clear-all and busy/ready stall
module regbank_writer
   import regbank_writer_pkg::*;
#(
   parameter int N_BITS   = DEF_N_BITS,
   parameter int SEL_BITS = DEF_SEL_BITS
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic [SEL_BITS-1:0]                  wr_sel,
   input  logic [N_BITS-1:0]                    wr_data,
   input  logic [n_lanes(N_BITS)-1:0]           wr_be,
   output logic                                 wr_ack,
   input  logic                                 clr_req,
   output logic                                 busy,
   output logic [n_regs(SEL_BITS)*N_BITS-1:0]   q_flat
);
   localparam int N_REGS  = n_regs(SEL_BITS);
   localparam int N_LANES = n_lanes(N_BITS);
   state_t              r_state;
   logic [SEL_BITS-1:0] r_cnt;
   logic                r_ack;
   logic                w_accept;
   logic [N_REGS-1:0]   w_wr_en;
   assign busy     = (r_state == ST_CLEARING);
   assign wr_ready = ~busy;
   assign w_accept = wr_valid && wr_ready;
   assign wr_ack   = r_ack;
   decoder_n #(.SEL_BITS(SEL_BITS)) u_dec (
      .i_en     (w_accept),
      .i_sel    (wr_sel),
      .o_onehot (w_wr_en)
   );
   // the counter wraps back to 0 on the edge that clears the last register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= |w_wr_en;
         if (r_state == ST_IDLE) begin
            if (clr_req) begin
               r_state <= ST_CLEARING;
               r_cnt   <= SEL_BITS'(1);
            end
         end else begin
            r_state <= (r_cnt == SEL_BITS'(N_REGS - 1)) ? ST_IDLE : ST_CLEARING;
            r_cnt   <= r_cnt + SEL_BITS'(1);
         end
      end
   end
   assign q_flat[N_BITS-1:0] = '0;
   for (genvar i = 1; i < N_REGS; i++) begin : g_reg
      logic [N_BITS-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            r_q <= '0;
         else if (busy && r_cnt == SEL_BITS'(i))
            r_q <= '0;
         else if (w_wr_en[i])
            for (int b = 0; b < N_LANES; b++)
               if (wr_be[b]) r_q[b*8 +: 8] <= wr_data[b*8 +: 8];
      end
      assign q_flat[i*N_BITS +: N_BITS] = r_q;
   end
endmodule

// File: tb/tb_regbank_writer.sv
// tb_regbank_writer: vector table plus ack-driven scoreboard for regbank_writer
module tb_regbank_writer;
   localparam int NB = 32;
   localparam int NR = 32;
   typedef struct {
      logic [4:0]  sel;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   typedef struct {
      logic [4:0]  sel;
      logic [31:0] exp;
   } sb_t;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          clr_req = 1'b0;
   logic [4:0]    wr_sel = '0;
   logic [31:0]   wr_data = '0;
   logic [3:0]    wr_be = '0;
   logic          wr_ready, wr_ack, busy;
   logic [NR*NB-1:0] q_flat;
   sb_t           sb[$];
   sb_t           mon_e;
   logic [31:0]   model[NR];
   vec_t          vt[7];
   int            checks = 0;
   int            errors = 0;
   regbank_writer #(.N_BITS(NB), .SEL_BITS(5)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
      .clr_req(clr_req), .busy(busy), .q_flat(q_flat)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] rd(input int i);
      return q_flat[i*NB +: NB];
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction
   task automatic chk_all(input string name);
      int bad = 0;
      for (int i = NR - 1; i >= 0; i--) if (rd(i) !== model[i]) bad = i;
      chk($sformatf("%s_reg%0d", name, bad), rd(bad), model[bad]);
   endtask
   task automatic drive_write(input logic [4:0] sel, input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp);
      wr_sel   = sel;
      wr_data  = d;
      wr_be    = be;
      wr_valid = 1'b1;
      sb.push_back('{sel, exp});
      if (sel != 0) model[sel] = exp;
   endtask
   task automatic do_write(input logic [4:0] sel, input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp);
      drive_write(sel, d, be, exp);
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask
   task automatic fill_all();
      for (int i = 1; i < NR; i++) do_write(5'(i), 32'(i), 4'hF, 32'(i));
   endtask
   always @(negedge clk) begin
      if (rst_n && wr_ack) begin
         if (sb.size() == 0)
            chk("ack_unexpected", {31'b0, wr_ack}, 32'd0);
         else begin
            mon_e = sb.pop_front();
            chk($sformatf("ack_reg%0d", mon_e.sel), rd(int'(mon_e.sel)), mon_e.exp);
         end
      end
   end
   initial begin
      int n;
      vt[0] = '{5'd5,  32'hDEADBEEF, 4'hF,    32'hDEADBEEF};
      vt[1] = '{5'd5,  32'h11223344, 4'b0011, 32'hDEAD3344};
      vt[2] = '{5'd0,  32'hFFFFFFFF, 4'hF,    32'h00000000};
      vt[3] = '{5'd31, 32'h12345678, 4'b1000, 32'h12000000};
      vt[4] = '{5'd31, 32'hAABBCCDD, 4'b0101, 32'h12BB00DD};
      vt[5] = '{5'd1,  32'hCAFEF00D, 4'b0000, 32'h00000000};
      vt[6] = '{5'd1,  32'hCAFEF00D, 4'b0110, 32'h00FEF000};
      for (int i = 0; i < NR; i++) model[i] = '0;
      repeat (2) @(negedge clk);
      chk_all("rst_q");
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_ready", {31'b0, wr_ready}, 32'd1);
      chk("rst_ack", {31'b0, wr_ack}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         do_write(vt[i].sel, vt[i].data, vt[i].be, vt[i].exp);
         chk($sformatf("vec%0d_ack", i), {31'b0, wr_ack}, 32'd1);
         chk($sformatf("vec%0d_model", i), merge(rd(int'(vt[i].sel)), 32'h0, 4'h0), vt[i].exp);
         @(negedge clk);
         chk($sformatf("vec%0d_ack_drop", i), {31'b0, wr_ack}, 32'd0);
      end
      chk_all("after_vec");
      // write and clear requested in the same idle cycle
      drive_write(5'd9, 32'h0BADCAFE, 4'hF, 32'h0BADCAFE);
      clr_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      clr_req  = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("same_cycle_busy_len", 32'(n), 32'd31);
      for (int i = 0; i < NR; i++) model[i] = '0;
      chk_all("same_cycle_cleared");
      fill_all();
      chk_all("filled");
      clr_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_req = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = '0;
      chk("clr_ready_low", {31'b0, wr_ready}, 32'd0);
      drive_write(5'd7, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5);
      n = 0;
      while (busy && n < 100) begin
         if (wr_ready) chk("ready_during_busy", {31'b0, wr_ready}, 32'd0);
         n++;
         @(negedge clk);
      end
      chk("busy_len", 32'(n), 32'd31);
      chk("ready_after_busy", {31'b0, wr_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      chk("stall_ack", {31'b0, wr_ack}, 32'd1);
      chk_all("after_clear");
      fill_all();
      clr_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_req = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      chk_all("midclr_rst_q");
      chk("midclr_rst_busy", {31'b0, busy}, 32'd0);
      chk("midclr_rst_ready", {31'b0, wr_ready}, 32'd1);
      chk("midclr_rst_ack", {31'b0, wr_ack}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_write(5'd3, 32'h13572468, 4'hF, 32'h13572468);
      chk("post_rst_ack", {31'b0, wr_ack}, 32'd1);
      @(negedge clk);
      chk_all("post_rst_write");
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
